// File: rtl/axi_pkg.sv
// axi_pkg: shared burst-writer FSM states and AXI3 write-channel constants
package axi_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/axi_burst_writer.sv
// axi_burst_writer: issues one AXI3 INCR write burst per start, fed from a FWFT FIFO
module axi_burst_writer
  import axi_pkg::*;
#(
  parameter logic [5:0] AWID_VAL = 6'd0,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      addr,
  input  logic [3:0]       burstlen,
  input  logic             start,
  output logic             busy,
  input  logic [31:0]      data,
  output logic             advance,
  output logic [5:0]       awid,
  output logic [31:0]      awaddr,
  output logic [3:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic             awvalid,
  input  logic             awready,
  output logic [5:0]       wid,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wlast,
  output logic             wvalid,
  input  logic             wready,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  output logic [ERR_W-1:0] err_count
);
  state_t state, state_nx;
  logic [31:0] addr_q;
  logic [3:0] len_q, beat;
  assign awid = AWID_VAL;
  assign wid = AWID_VAL;
  assign awsize = SIZE_4B;
  assign awburst = BURST_INCR;
  assign wstrb = 4'hF;
  assign awaddr = addr_q;
  assign awlen = len_q;
  assign wdata = data;
  assign busy = state != IDLE;
  // state register; reset abandons any burst in flight
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // burst parameters are captured only when idle, so start while busy is ignored
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr_q <= '0;
      len_q <= '0;
    end else if (state == IDLE && start) begin
      addr_q <= addr & ~32'h3;
      len_q <= burstlen;
    end
  // beat index restarts as the address handshake hands over to the data phase
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) beat <= '0;
    else if (state == ADDR && awready) beat <= '0;
    else if (advance) beat <= beat + 4'd1;
  // saturating count of error responses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_count <= '0;
    else if (state == RESP && bvalid && bresp != RESP_OKAY && err_count != '1)
      err_count <= err_count + ERR_W'(1);
  // next state and per-state channel strobes
  always_comb begin
    state_nx = state;
    awvalid = 1'b0;
    wvalid = 1'b0;
    wlast = 1'b0;
    bready = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: state_nx = start ? ADDR : IDLE;
      ADDR: begin
        awvalid = 1'b1;
        state_nx = awready ? DATA : ADDR;
      end
      DATA: begin
        wvalid = 1'b1;
        wlast = beat == len_q;
        advance = wready;
        state_nx = (wready && wlast) ? RESP : DATA;
      end
      default: begin
        bready = 1'b1;
        state_nx = bvalid ? IDLE : RESP;
      end
    endcase
  end
endmodule

// File: tb/tb_axi_burst_writer.sv
// tb_axi_burst_writer: directed bursts checked every cycle against a transaction-count model
module tb_axi_burst_writer;
  logic clk = 0, reset_n = 0, start = 0, awready = 0, wready = 1, bvalid = 1;
  logic [31:0] addr = 0, data = 32'hD000_0000;
  logic [3:0] burstlen = 0;
  logic [1:0] bresp = 0;
  logic busy, advance, awvalid, wlast, wvalid, bready;
  logic [5:0] awid, wid;
  logic [31:0] awaddr, wdata;
  logic [3:0] awlen, wstrb;
  logic [2:0] awsize, err_count;
  logic [1:0] awburst;
  int errors = 0, checks = 0, cyc = 0;
  int aw_hs = 0, adv_cnt = 0, wv_cnt = 0, wlast_at = -1, aw_delay = 0, aw_wait = 0, w_stall = 0;
  logic [31:0] last_awaddr = 0;
  logic [3:0] last_awlen = 0;
  logic pop_pending = 0;
  bit m_active, m_aw;
  int m_beats, m_len, m_errs;
  logic [31:0] m_addr;

  axi_burst_writer #(.AWID_VAL(6'h2A), .ERR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .burstlen(burstlen), .start(start),
    .busy(busy), .data(data), .advance(advance), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .err_count(err_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // model: a burst is a count of completed phases, not a state encoding
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_active = 0; m_aw = 0; m_beats = 0; m_len = 0; m_addr = 0; m_errs = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_aw = 0; m_beats = 0; m_len = int'(burstlen);
        m_addr = {addr[31:2], 2'b00};
      end
    end else if (!m_aw) m_aw = awready;
    else if (m_beats <= m_len) m_beats += int'(wready);
    else if (bvalid) begin
      m_active = 0;
      if (bresp != 2'b00) m_errs++;
    end

  // responder: awready after aw_delay waiting cycles, wready stalled w_stall cycles, FIFO pops
  always @(posedge clk) begin
    #1;
    if (awvalid) begin
      awready = aw_wait >= aw_delay;
      aw_wait++;
    end else begin
      awready = 0;
      aw_wait = 0;
    end
    if (wvalid && w_stall > 0) begin
      wready = 0;
      w_stall--;
    end else wready = 1;
    if (pop_pending) data = data + 32'h0101_0101;
    pop_pending = 0;
  end

  // compare every cycle against the model and keep per-burst tallies
  always @(negedge clk) begin
    bit e_wv;
    e_wv = m_active && m_aw && m_beats <= m_len;
    chk("busy", busy, m_active);
    chk("awvalid", awvalid, m_active && !m_aw);
    chk("wvalid", wvalid, e_wv);
    chk("bready", bready, m_active && m_aw && m_beats > m_len);
    chk("wlast", wlast, e_wv && m_beats == m_len);
    chk("advance", advance, e_wv && wready);
    chk("err_count", err_count, m_errs > 7 ? 7 : m_errs);
    chk("fixed", {awid, wid, awsize, awburst, wstrb}, {6'h2A, 6'h2A, 3'b010, 2'b01, 4'hF});
    if (awvalid) chk("awaddr", awaddr, m_addr);
    if (awvalid) chk("awlen", awlen, m_len);
    if (wvalid) chk("wdata", wdata, data);
    if (awvalid && awready) begin
      aw_hs++;
      last_awaddr = awaddr;
      last_awlen = awlen;
    end
    if (wvalid) wv_cnt++;
    if (advance) begin
      if (wlast) wlast_at = adv_cnt;
      adv_cnt++;
      pop_pending = 1;
    end
  end

  task automatic clear();
    aw_hs = 0; adv_cnt = 0; wv_cnt = 0; wlast_at = -1;
  endtask

  task automatic start_burst(logic [31:0] a, logic [3:0] l);
    @(posedge clk); #1;
    addr = a; burstlen = l; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {awvalid, wvalid, wlast, bready, advance}, 5'b0);
    chk("rst_err", err_count, 0);
    #1 reset_n = 1;
    // unaligned address, four beats, no back-pressure
    clear();
    start_burst(32'h1000_0043, 4'd3);
    wait_idle();
    chk("t1_awaddr", last_awaddr, 32'h1000_0040);
    chk("t1_awlen", last_awlen, 3);
    chk("t1_adv", adv_cnt, 4);
    chk("t1_wlast_beat", wlast_at, 3);
    chk("t1_busy", busy, 0);
    // single beat with five stalled cycles
    clear();
    w_stall = 5;
    start_burst(32'h0000_2000, 4'd0);
    wait_idle();
    chk("t2_adv", adv_cnt, 1);
    chk("t2_wlast_beat", wlast_at, 0);
    chk("t2_wvalid_cycles", wv_cnt, 6);
    // start held every cycle through a 16-beat burst with changing addr/len
    clear();
    @(posedge clk); #1;
    addr = 32'h2000_0100; burstlen = 4'd15; start = 1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      addr = $urandom; burstlen = 4'($urandom);
      if (wvalid && wlast && wready) break;
    end
    start = 0;
    wait_idle();
    chk("t3_aw_hs", aw_hs, 1);
    chk("t3_awlen", last_awlen, 15);
    chk("t3_awaddr", last_awaddr, 32'h2000_0100);
    chk("t3_adv", adv_cnt, 16);
    // error responses: three, then OKAY, then saturation of the 3-bit counter
    for (int i = 0; i < 3; i++) begin
      bresp = 2'b10;
      start_burst(32'h3000_0000 + 32'(i * 16), 4'd1);
      wait_idle();
    end
    bresp = 2'b00;
    start_burst(32'h3000_0100, 4'd0);
    wait_idle();
    chk("t4_err3", err_count, 3);
    for (int i = 0; i < 5; i++) begin
      bresp = 2'b11;
      start_burst(32'h3000_0200, 4'd0);
      wait_idle();
    end
    bresp = 2'b00;
    chk("t4_err_sat", err_count, 7);
    // asynchronous reset during beat 2 of 8
    clear();
    start_burst(32'h4000_0000, 4'd7);
    for (int n = 0; n < 100 && adv_cnt < 2; n++) @(posedge clk);
    #3 reset_n = 0;
    #1;
    chk("t5_rst_valids", {awvalid, wvalid, advance, bready}, 4'b0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_err", err_count, 0);
    @(posedge clk); #1 reset_n = 1;
    clear();
    start_burst(32'h4000_1000, 4'd7);
    wait_idle();
    chk("t5_fresh_aw", aw_hs, 1);
    chk("t5_fresh_addr", last_awaddr, 32'h4000_1000);
    chk("t5_fresh_adv", adv_cnt, 8);
    // start held high with slow awready: one idle cycle between response and next AW
    clear();
    aw_delay = 4;
    @(posedge clk); #1;
    addr = 32'h5000_0000; burstlen = 4'd1; start = 1;
    begin
      int n, c1, c2;
      n = 0;
      do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < 100);
      c1 = cyc;
      n = 0;
      do begin @(negedge clk); n++; end while (!awvalid && n < 100);
      c2 = cyc;
      chk("t6_turnaround", c2 - c1, 2);
    end
    @(posedge clk); #1 start = 0;
    wait_idle();
    chk("t6_aw_hs", aw_hs, 2);
    chk("t6_adv", adv_cnt, 4);
    aw_delay = 0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
